// File: rtl/rw_pkg.sv
// Shared widths and state encoding for the ReadWrite arbiter.
package rw_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic                     any_req
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt     = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rw_arbiter.sv
// Round-robin front end that shares one ReadWrite FSM between N_REQ requesters,
// latching the winner's request, retrying failed attempts and returning a one-cycle response.
module rw_arbiter
    import rw_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_err,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    busy,
    output logic                    read,
    output logic                    tran_ready,
    output logic [ADDR_W-1:0]       rw_addr,
    output logic [DATA_W-1:0]       data_down_rw,
    input  logic                    done,
    input  logic                    cancel,
    input  logic                    recv_ready,
    input  logic [DATA_W-1:0]       data_up_rw
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_t        state, next_state;
    logic [PTR_W-1:0]  ptr, gnt_idx, arb_idx;
    logic [N_REQ-1:0]  arb_gnt;
    logic              any_req;
    logic              lat_read;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  retry_cnt;
    logic              err;
    logic              failure;
    logic              can_retry;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .any_req (any_req)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
    end

    // cancel dominates; a read that finishes without recv_ready also counts as failed
    assign failure   = cancel | (lat_read & ~recv_ready);
    assign can_retry = retry_cnt < CNT_W'(MAX_RETRY);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = BUSY;
            BUSY:    if (done) next_state = (failure && can_retry) ? ISSUE : RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ptr       <= PTR_W'(N_REQ - 1);
            gnt_idx   <= '0;
            lat_read  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            retry_cnt <= '0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_idx   <= arb_idx;
                    lat_read  <= req_read[arb_idx];
                    lat_addr  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                    lat_wdata <= req_wdata[arb_idx*DATA_W +: DATA_W];
                    retry_cnt <= '0;
                    err       <= 1'b0;
                    rdata     <= '0;
                end
                BUSY: if (done) begin
                    if (failure && can_retry) begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end else if (failure) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        err   <= 1'b0;
                        rdata <= lat_read ? data_up_rw : '0;
                    end
                end
                RESP:    ptr <= gnt_idx;
                default: ;
            endcase
        end
    end

    // Outputs decode from state only, so an async reset clears them in the same cycle.
    always_comb begin
        resp_valid   = '0;
        resp_err     = 1'b0;
        resp_rdata   = '0;
        read         = 1'b0;
        tran_ready   = 1'b0;
        rw_addr      = '0;
        data_down_rw = '0;
        busy         = (state != IDLE);
        case (state)
            ISSUE: begin
                tran_ready   = 1'b1;
                read         = lat_read;
                rw_addr      = lat_addr;
                data_down_rw = lat_wdata;
            end
            BUSY: begin
                read         = lat_read;
                rw_addr      = lat_addr;
                data_down_rw = lat_wdata;
            end
            RESP: begin
                resp_valid[gnt_idx] = 1'b1;
                resp_err            = err;
                resp_rdata          = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rw_arbiter.sv
// Randomized scoreboard bench for rw_arbiter with a ReadWrite responder model.
module tb_rw_arbiter;
    import rw_pkg::*;

    localparam int N  = 4;
    localparam int MR = 3;

    logic                clk = 1'b0;
    logic                rst_L = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        req_read = '0;
    logic [N*ADDR_W-1:0] req_addr = '0;
    logic [N*DATA_W-1:0] req_wdata = '0;
    logic [N-1:0]        resp_valid;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_rdata;
    logic                busy, read, tran_ready;
    logic [ADDR_W-1:0]   rw_addr;
    logic [DATA_W-1:0]   data_down_rw;
    logic                done = 1'b0, cancel = 1'b0, recv_ready = 1'b0;
    logic [DATA_W-1:0]   data_up_rw = '0;

    rw_arbiter #(.N_REQ(N), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_L(rst_L), .req(req), .req_read(req_read), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .busy(busy), .read(read), .tran_ready(tran_ready),
        .rw_addr(rw_addr), .data_down_rw(data_down_rw), .done(done), .cancel(cancel),
        .recv_ready(recv_ready), .data_up_rw(data_up_rw)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        rd;
        logic [15:0] addr;
        logic [63:0] wdata;
        int          fails;   // attempts the responder will fail before succeeding
        logic [63:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   mptr = N - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    // Round-robin rule: the first pending requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            req_read[i]              = 1'($urandom_range(0, 1));
            req_addr[i*ADDR_W +: ADDR_W] = 16'($urandom);
            req_wdata[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
    endtask

    task automatic start(input logic [N-1:0] r, input int fails, input int rd_mode,
                         input logic [63:0] rdata);
        txn_t t;
        rand_fields();
        t.idx = pick(r, mptr);
        mptr  = t.idx;
        if (rd_mode >= 0) req_read[t.idx] = (rd_mode == 1);
        t.rd    = req_read[t.idx];
        t.addr  = req_addr[t.idx*ADDR_W +: ADDR_W];
        t.wdata = req_wdata[t.idx*DATA_W +: DATA_W];
        t.fails = fails;
        t.rdata = rdata;
        req = r;
        exp_q.push_back(t);
    endtask

    task automatic wait_tran();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tran_ready) return;
        end
        fail_now("grant_wait");
    endtask

    task automatic wait_resp();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (resp_valid != '0) return;
        end
        fail_now("resp_wait");
    endtask

    task automatic run_txn(input logic [N-1:0] r, input int fails, input int rd_mode,
                           input logic [63:0] rdata, input bit scramble, input int gap);
        start(r, fails, rd_mode, rdata);
        wait_tran();
        if (scramble) begin
            rand_fields();
            req = N'($urandom);
        end
        wait_resp();
        if (gap > 0) begin
            req = '0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // ReadWrite responder: answers each tran_ready after a random delay.
    txn_t rsp_plan;
    int   rsp_att = 0;
    bit   rsp_fresh = 0;
    initial begin
        forever begin
            if (!rsp_fresh) @(negedge clk);
            rsp_fresh = 0;
            if (!rst_L) begin
                done = 0; cancel = 0; recv_ready = 0; rsp_att = 0;
                continue;
            end
            if (resp_valid != '0) rsp_att = 0;
            if (tran_ready) begin
                done = 0; cancel = 0; recv_ready = 0;
                if (exp_q.size() > 0) rsp_plan = exp_q[0];
                else rsp_plan = '{idx: 0, rd: 1'b0, addr: '0, wdata: '0, fails: 0, rdata: '0};
                begin
                    int d;
                    d = $urandom_range(0, 3);
                    for (int k = 0; k <= d; k++) begin
                        @(negedge clk);
                        if (!rst_L) break;
                        cancel     = 1'($urandom_range(0, 1));
                        recv_ready = 1'($urandom_range(0, 1));
                    end
                end
                if (!rst_L) begin
                    rsp_fresh = 1;
                    continue;
                end
                done = 1;
                if (rsp_att < rsp_plan.fails) begin
                    int kind;
                    kind = $urandom_range(0, rsp_plan.rd ? 2 : 1);
                    cancel     = (kind != 2);
                    recv_ready = (kind == 1);
                    data_up_rw = {$urandom, $urandom};
                end else begin
                    cancel     = 0;
                    recv_ready = rsp_plan.rd ? 1'b1 : 1'($urandom_range(0, 1));
                    data_up_rw = rsp_plan.rdata;
                end
                @(negedge clk);
                done = 0; cancel = 0; recv_ready = 0;
                data_up_rw = {$urandom, $urandom};
                rsp_att++;
                rsp_fresh = 1;
            end else if ((!busy || resp_valid != '0) && $urandom_range(0, 3) == 0) begin
                done       = 1;
                cancel     = 1'($urandom_range(0, 1));
                recv_ready = 1'($urandom_range(0, 1));
            end else begin
                done = 0; cancel = 0; recv_ready = 0;
            end
        end
    end

    // Monitor: compares every DUT presentation against the head of the scoreboard.
    int mon_att = 0;
    bit mon_prev_tr = 0;
    bit mon_after_resp = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_L) begin
                mon_att = 0; mon_prev_tr = 0; mon_after_resp = 0;
                continue;
            end
            if (mon_after_resp) check("idle_after_resp", 64'(busy), 64'(0));
            mon_after_resp = 0;
            if (!busy) begin
                check("idle_ctrl", 64'({tran_ready, resp_valid, read}), 64'(0));
                check("idle_addr", 64'(rw_addr), 64'(0));
                check("idle_wdata", data_down_rw, 64'(0));
            end else if (exp_q.size() == 0) begin
                if (tran_ready || resp_valid != '0) fail_now("unexpected_activity");
            end else begin
                txn_t t;
                t = exp_q[0];
                if (tran_ready) begin
                    mon_att++;
                    check("tran_pulse_single", 64'(mon_prev_tr), 64'(0));
                    check("issue_read", 64'(read), 64'(t.rd));
                    check("issue_addr", 64'(rw_addr), 64'(t.addr));
                    check("issue_wdata", data_down_rw, t.wdata);
                end else if (resp_valid != '0) begin
                    bit e_err;
                    int e_att;
                    e_err = (t.fails > MR);
                    e_att = e_err ? MR + 1 : t.fails + 1;
                    check("resp_onehot", 64'(resp_valid), 64'(1) << t.idx);
                    check("resp_err", 64'(resp_err), 64'(e_err));
                    check("resp_rdata", resp_rdata, (!e_err && t.rd) ? t.rdata : 64'(0));
                    check("attempts", 64'(mon_att), 64'(e_att));
                    check("resp_datapath_zero", 64'({read, rw_addr}) | data_down_rw, 64'(0));
                    void'(exp_q.pop_front());
                    mon_att = 0;
                    mon_after_resp = 1;
                end else begin
                    check("busy_read", 64'(read), 64'(t.rd));
                    check("busy_addr", 64'(rw_addr), 64'(t.addr));
                    check("busy_wdata", data_down_rw, t.wdata);
                end
            end
            if (resp_valid == '0) check("rdata_quiet", resp_rdata, 64'(0));
            mon_prev_tr = tran_ready;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, tran_ready, read, resp_err, resp_valid}), 64'(0));
        check("reset_addr", 64'(rw_addr), 64'(0));
        check("reset_wdata", data_down_rw, 64'(0));
        check("reset_rdata", resp_rdata, 64'(0));
        rst_L = 1'b1;
        @(negedge clk);

        // All requesters held high: rotation 0,1,2,3,0 from reset.
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, -1, {$urandom, $urandom}, 0, (i == 4) ? 1 : 0);
        run_txn(4'b0001, 0, 0, 64'(0), 0, 1);
        run_txn(4'b0100, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 1);
        run_txn(4'b0010, 0, -1, {$urandom, $urandom}, 0, 0);
        run_txn(4'b0111, 0, -1, {$urandom, $urandom}, 0, 1);
        run_txn(4'b0010, 2, 1, {$urandom, $urandom}, 0, 1);
        run_txn(4'b1000, 4, 0, 64'(0), 0, 1);
        run_txn(4'b0100, 1, -1, {$urandom, $urandom}, 1, 1);

        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] r;
            int sel, f;
            r = N'($urandom_range(1, (1 << N) - 1));
            sel = $urandom_range(0, 9);
            f = (sel < 5) ? 0 : (sel < 8) ? $urandom_range(1, MR) : $urandom_range(MR + 1, MR + 2);
            run_txn(r, f, -1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while the ReadWrite FSM is mid-transaction.
        start(4'b0001, 0, -1, {$urandom, $urandom});
        wait_tran();
        @(posedge clk);
        #2;
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst_L = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({busy, tran_ready, read, resp_err, resp_valid}), 64'(0));
        check("rst_mid_addr", 64'(rw_addr), 64'(0));
        check("rst_mid_wdata", data_down_rw, 64'(0));
        check("rst_mid_rdata", resp_rdata, 64'(0));
        req = '0;
        exp_q.delete();
        mptr = N - 1;
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        run_txn(4'b1000, 0, -1, {$urandom, $urandom}, 0, 3);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
